alu_mdu: RTL

Parametrised multi-cycle arithmetic unit for the CPU datapath: the single-cycle integer operations plus iterative signed/unsigned multiply and divide. All operations use one start/done handshake. Multiply/divide results go to dedicated HI/LO registers. Sits in the execute stage; the controller stalls on `busy` and the register-file/HI-LO write paths consume `result`, `hi` and `lo` on `done`.

---
 rtl/alu_mdu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// Execute-stage arithmetic unit: single-cycle integer ops plus iterative
// signed/unsigned multiply and divide sharing one start/done handshake.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       order,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [4:0] OP_ADDU = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUBU = 5'h02;
  localparam logic [4:0] OP_SUB  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_XOR  = 5'h06;
  localparam logic [4:0] OP_NOR  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08;
  localparam logic [4:0] OP_SRA  = 5'h09;
  localparam logic [4:0] OP_SLL  = 5'h0A;
  localparam logic [4:0] OP_SLT  = 5'h0B;
  localparam logic [4:0] OP_SLTU = 5'h0C;

  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;
  state_t state, state_nxt;

  logic [4:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, mcand;
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
    return c ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic c);
    return c ? -v : v;
  endfunction

  logic md_in, accept;
  assign md_in  = (order[4:2] == 3'b100);
  assign accept = start && ((state == IDLE) || (state == FIN));
  assign busy   = (state == RUN) || (state == FIX);
  assign done   = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: state_nxt = start ? (md_in ? RUN : FIN) : IDLE;
      RUN:       if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:       state_nxt = FIN;
      default:   state_nxt = IDLE;
    endcase
  end

  // single-cycle datapath, evaluated straight from the live operands
  logic [WIDTH:0]          add_w, sub_w;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_carry, sc_neg, sc_ovf, sc_known;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign a_s   = a;
  assign b_s   = b;
  assign shamt = a[SHW-1:0];

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_neg   = 1'b0;
    sc_ovf   = 1'b0;
    sc_known = 1'b1;
    case (order)
      OP_ADDU: begin sc_res = add_w[WIDTH-1:0]; sc_carry = add_w[WIDTH]; end
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
        sc_neg = sc_res[WIDTH-1];
      end
      OP_SUBU: begin sc_res = sub_w[WIDTH-1:0]; sc_carry = sub_w[WIDTH]; end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
        sc_neg = sc_res[WIDTH-1];
      end
      OP_OR:   sc_res = a | b;
      OP_AND:  sc_res = a & b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SRL:  sc_res = b >> shamt;
      OP_SRA:  sc_res = b_s >>> shamt;
      OP_SLL:  sc_res = b << shamt;
      OP_SLT: begin
        sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
        sc_neg = sc_res[WIDTH-1];
      end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: sc_known = 1'b0;
    endcase
  end

  // iterative step: acc is {partial product} for mul, {remainder, quotient} for div
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, mcand};

  logic               sgn_a, sgn_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_ovf, fix_dz;

  assign sgn_a = ~op_r[0] && a_r[WIDTH-1];
  assign sgn_b = ~op_r[0] && b_r[WIDTH-1];

  always_comb begin
    fix_hi   = '0;
    fix_lo   = '0;
    fix_ovf  = 1'b0;
    fix_dz   = 1'b0;
    prod_fix = neg_if_wide(acc, sgn_a ^ sgn_b);
    if (op_r[1]) begin
      if (b_r == '0) begin
        fix_lo = '1;
        fix_hi = a_r;
        fix_dz = 1'b1;
      end else begin
        fix_lo = neg_if(acc[WIDTH-1:0], sgn_a ^ sgn_b);
        fix_hi = neg_if(acc[2*WIDTH-1:WIDTH], sgn_a);
      end
      fix_ovf = ~op_r[0] && (a_r == MOST_NEG) && (b_r == '1);
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // working registers of the iterative engine carry no reset
  always_ff @(posedge clk) begin
    if (accept && md_in) begin
      op_r  <= order;
      a_r   <= a;
      b_r   <= b;
      mcand <= magnitude(b, ~order[0]);
      acc   <= {{WIDTH{1'b0}}, magnitude(a, ~order[0])};
      cnt   <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + SHW'(1);
      if (op_r[1])
        acc <= div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc <= {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      hi       <= '0;
      lo       <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !md_in) begin
        result   <= sc_res;
        zero     <= sc_known && (sc_res == '0);
        carry    <= sc_carry;
        negative <= sc_neg;
        overflow <= sc_ovf;
        div_zero <= 1'b0;
      end else if (state == FIX) begin
        hi       <= fix_hi;
        lo       <= fix_lo;
        result   <= fix_lo;
        zero     <= (fix_lo == '0);
        carry    <= 1'b0;
        negative <= 1'b0;
        overflow <= fix_ovf;
        div_zero <= fix_dz;
      end
    end
  end

endmodule
